i2c_key_scheduler: RTL and testbench

Sits between the USB key decoder and the I2C master. It buffers decoded key codes in a small FIFO and sequences one I2C write transaction per key (device address plus one data byte). On NACK it retries after a backoff gap, up to a retry limit. It reports overflow and dropped-key errors through sticky flags.

---
 rtl/i2c_key_scheduler.sv | 146 ++++++++++++++
 tb/tb_i2c_key_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_key_scheduler.sv
// Buffers decoded key codes and sends each one to the I2C master as a single
// write transaction, retrying NACKed writes after a backoff gap.
module i2c_key_scheduler #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [6:0] DEV_ADDR   = 7'h27,
    parameter int         MAX_RETRY  = 3,
    parameter int         RETRY_GAP  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [7:0]                    key_code,
    output logic                          key_ready,
    output logic                          i2c_start,
    output logic [6:0]                    i2c_addr,
    output logic [7:0]                    i2c_data,
    input  logic                          i2c_busy,
    input  logic                          i2c_done,
    input  logic                          i2c_nack,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          drop_err,
    input  logic                          clear_err,
    output logic [1:0]                    state_dbg
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = $clog2(MAX_RETRY + 1) + 1;
    localparam int GW = $clog2(RETRY_GAP + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BACKOFF} state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    logic [LW-1:0]   level_next;
    logic [RW-1:0]   retry_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            key_seen;
    logic            push;
    logic            ovf_event;
    logic            retry_spent;
    logic            give_up;
    logic            pop;

    // Handshakes: a nonzero key_code is taken on every edge where key_valid and
    // key_ready are both high (valid with ready low discards it and raises
    // overflow); i2c_start opens one transaction, closed by the i2c_done pulse
    // in WAIT, with i2c_nack meaningful only alongside i2c_done.
    assign key_seen    = key_valid && (key_code != 8'h00);
    assign push        = key_seen && key_ready;
    assign ovf_event   = key_seen && !key_ready;
    assign retry_spent = (retry_cnt == RW'(MAX_RETRY));
    assign give_up     = (state == WAIT) && i2c_done && i2c_nack && retry_spent;
    assign pop         = (state == WAIT) && i2c_done && (!i2c_nack || retry_spent);

    assign i2c_addr   = DEV_ADDR;
    assign fifo_level = level;
    assign state_dbg  = state;

    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + 1'b1;
        end else if (!push && pop) begin
            level_next = level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= key_code;
        end
    end

    // key_ready follows the registered level, so a same-cycle pop never opens
    // a slot for a push into a full buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            key_ready <= 1'b1;
            overflow  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level     <= level_next;
            key_ready <= (level_next != LW'(FIFO_DEPTH));
            overflow  <= ovf_event | (overflow & ~clear_err);
            drop_err  <= give_up | (drop_err & ~clear_err);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            i2c_start <= 1'b0;
            i2c_data  <= 8'h00;
            retry_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            i2c_start <= 1'b0;
            case (state)
                IDLE: begin
                    if ((level != '0) && !i2c_busy) begin
                        i2c_data <= mem[rd_ptr];
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    i2c_start <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (i2c_done) begin
                        if (!i2c_nack || retry_spent) begin
                            retry_cnt <= '0;
                            state     <= IDLE;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            gap_cnt   <= GW'(RETRY_GAP);
                            state     <= BACKOFF;
                        end
                    end
                end
                BACKOFF: begin
                    // The head byte stays in i2c_data; the retry resends it as is.
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (!i2c_busy) begin
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_key_scheduler.sv
// Self-checking bench for i2c_key_scheduler: directed scenarios followed by
// randomized key bursts, checked against a queue-based model of the key path.
module tb_i2c_key_scheduler;
    localparam int FIFO_DEPTH = 8;
    localparam int MAX_RETRY  = 3;
    localparam int RETRY_GAP  = 16;

    logic       clk;
    logic       rst;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready;
    logic       i2c_start;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_data;
    logic       i2c_busy;
    logic       i2c_done;
    logic       i2c_nack;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       drop_err;
    logic       clear_err;
    logic [1:0] state_dbg;

    i2c_key_scheduler #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .DEV_ADDR  (7'h27),
        .MAX_RETRY (MAX_RETRY),
        .RETRY_GAP (RETRY_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .i2c_start (i2c_start),
        .i2c_addr  (i2c_addr),
        .i2c_data  (i2c_data),
        .i2c_busy  (i2c_busy),
        .i2c_done  (i2c_done),
        .i2c_nack  (i2c_nack),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .drop_err  (drop_err),
        .clear_err (clear_err),
        .state_dbg (state_dbg)
    );

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    int         exp_starts = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovf = 1'b0;
    bit         exp_drop = 1'b0;

    // Clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i2c_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of the key buffer: admission and overflow only.
    task automatic model_push(input logic [7:0] code);
        if (code != 8'h00) begin
            if (exp_q.size() == FIFO_DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(code);
        end
    endtask

    task automatic push_key(input logic [7:0] code);
        key_valid = 1'b1;
        key_code  = code;
        model_push(code);
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        exp_ovf   = 1'b0;
        exp_drop  = 1'b0;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        while (i2c_start !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = (i2c_start === 1'b1);
        check("start_seen", ok, 1);
    endtask

    // Plays the I2C master for one key: NACKs the first `nacks` attempts.
    task automatic serve_key(input int nacks, input bit push_on_done, input logic [7:0] pcode);
        logic [7:0] head;
        int         attempts;
        int         last_done;
        bit         ok;
        bit         nk;
        head      = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        attempts  = (nacks > MAX_RETRY) ? MAX_RETRY + 1 : nacks + 1;
        last_done = 0;
        for (int a = 0; a < attempts; a++) begin
            wait_start(ok);
            exp_starts++;
            check("i2c_data", i2c_data, head);
            check("i2c_addr", i2c_addr, 7'h27);
            if (a > 0) check("retry_gap_ok", (cyc - last_done) >= RETRY_GAP, 1);
            nk = (a < nacks);
            i2c_busy = 1'b1;
            @(negedge clk);
            check("start_one_cycle", i2c_start, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("data_stable", i2c_data, head);
            i2c_done = 1'b1;
            i2c_nack = nk;
            if (push_on_done && a == attempts - 1) begin
                key_valid = 1'b1;
                key_code  = pcode;
            end
            @(negedge clk);
            i2c_done  = 1'b0;
            i2c_nack  = 1'b0;
            i2c_busy  = 1'b0;
            key_valid = 1'b0;
            key_code  = 8'h00;
            last_done = cyc;
        end
        if (push_on_done) model_push(pcode);
        void'(exp_q.pop_front());
        if (nacks > MAX_RETRY) exp_drop = 1'b1;
        check("fifo_level", fifo_level, exp_q.size());
        check("key_ready", key_ready, exp_q.size() != FIFO_DEPTH);
        check("drop_err", drop_err, exp_drop);
        check("start_count", start_cnt, exp_starts);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_key_ready"}, key_ready, 1);
        check({tag, "_i2c_start"}, i2c_start, 0);
        check({tag, "_i2c_data"}, i2c_data, 0);
        check({tag, "_fifo_level"}, fifo_level, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_drop_err"}, drop_err, 0);
        check({tag, "_i2c_addr"}, i2c_addr, 7'h27);
    endtask

    initial begin
        bit         ok;
        int         n;
        logic [7:0] code;
        rst = 1'b1; key_valid = 1'b0; key_code = 8'h00;
        i2c_busy = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0; clear_err = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single key: start pulse two edges after the accepting edge.
        push_key(8'h04);
        check("lat_level", fifo_level, 1);
        check("lat_start_e0", i2c_start, 0);
        @(negedge clk);
        check("lat_start_e1", i2c_start, 0);
        @(negedge clk);
        check("lat_start_e2", i2c_start, 1);
        serve_key(0, 1'b0, 8'h00);

        // Ordering and backpressure with the master busy.
        i2c_busy = 1'b1;
        for (int i = 0; i < 8; i++) push_key(8'h04 + 8'(i));
        check("full_level", fifo_level, 8);
        check("full_key_ready", key_ready, 0);
        push_key(8'h0C);
        check("ovf_set", overflow, exp_ovf);
        check("ovf_level", fifo_level, 8);
        pulse_clear();
        check("ovf_cleared", overflow, 0);
        clear_err = 1'b1;
        exp_ovf   = 1'b0;
        push_key(8'h0D);
        clear_err = 1'b0;
        check("ovf_set_beats_clear", overflow, exp_ovf);
        i2c_busy = 1'b0;
        for (int i = 0; i < 8; i++) serve_key(0, 1'b0, 8'h00);
        repeat (40) @(negedge clk);
        check("drain_no_extra_start", start_cnt, exp_starts);
        pulse_clear();

        // Every attempt NACKed: dropped after MAX_RETRY retries.
        i2c_busy = 1'b1;
        push_key(8'h1E);
        push_key(8'h1F);
        i2c_busy = 1'b0;
        serve_key(MAX_RETRY + 1, 1'b0, 8'h00);
        serve_key(0, 1'b0, 8'h00);
        pulse_clear();
        check("drop_cleared", drop_err, 0);

        // One NACK then ACK; next key needs a fresh retry budget.
        i2c_busy = 1'b1;
        push_key(8'h2C);
        push_key(8'h2D);
        i2c_busy = 1'b0;
        serve_key(1, 1'b0, 8'h00);
        serve_key(MAX_RETRY, 1'b0, 8'h00);

        // Zero key code is ignored.
        for (int i = 0; i < 3; i++) push_key(8'h00);
        repeat (10) @(negedge clk);
        check("zero_level", fifo_level, 0);
        check("zero_overflow", overflow, exp_ovf);
        check("zero_no_start", start_cnt, exp_starts);

        // Push and pop on the same edge at level 3.
        i2c_busy = 1'b1;
        push_key(8'h31);
        push_key(8'h32);
        push_key(8'h33);
        check("pp_level_before", fifo_level, 3);
        i2c_busy = 1'b0;
        serve_key(0, 1'b1, 8'h34);
        check("pp_level_after", fifo_level, 3);
        for (int i = 0; i < 3; i++) serve_key(0, 1'b0, 8'h00);

        // Randomized bursts.
        for (int r = 0; r < 6; r++) begin
            i2c_busy = 1'b1;
            n = $urandom_range(1, 11);
            for (int i = 0; i < n; i++) begin
                code = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                push_key(code);
            end
            check("rnd_level", fifo_level, exp_q.size());
            check("rnd_key_ready", key_ready, exp_q.size() != FIFO_DEPTH);
            check("rnd_overflow", overflow, exp_ovf);
            if ($urandom_range(0, 1) == 1) begin
                pulse_clear();
                check("rnd_clear_ovf", overflow, 0);
                check("rnd_clear_drop", drop_err, 0);
            end
            i2c_busy = 1'b0;
            while (exp_q.size() > 0) serve_key($urandom_range(0, 5), 1'b0, 8'h00);
        end

        // Reset while a transaction is outstanding.
        i2c_busy = 1'b1;
        push_key(8'h40);
        push_key(8'h41);
        i2c_busy = 1'b0;
        wait_start(ok);
        exp_starts++;
        i2c_busy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check_reset_values("midreset");
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_drop = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        i2c_busy = 1'b0;
        @(negedge clk);
        i2c_done = 1'b1;
        @(negedge clk);
        i2c_done = 1'b0;
        repeat (30) @(negedge clk);
        check("stray_done_level", fifo_level, 0);
        check("stray_done_drop", drop_err, 0);
        check("stray_done_data", i2c_data, 0);
        check("stray_done_no_start", start_cnt, exp_starts);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
